// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline burst adaptor.
// The slave modport is the adaptor's view; master is the driving environment.
interface cacheline_burst_adaptor_if #(
    parameter int unsigned SLine  = 256,
    parameter int unsigned SBurst = 64
);

    // Cache side
    logic              read_i;
    logic              write_i;
    logic [31:0]       address_i;
    logic [SLine-1:0]  line_i;
    logic [SLine-1:0]  line_o;
    logic              resp_o;

    // Memory side
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic [SBurst-1:0] burst_o;
    logic [SBurst-1:0] burst_i;
    logic              resp_i;

    modport slave (
        input  read_i,
        input  write_i,
        input  address_i,
        input  line_i,
        input  burst_i,
        input  resp_i,
        output line_o,
        output resp_o,
        output address_o,
        output read_o,
        output write_o,
        output burst_o
    );

    modport master (
        output read_i,
        output write_i,
        output address_i,
        output line_i,
        output burst_i,
        output resp_i,
        input  line_o,
        input  resp_o,
        input  address_o,
        input  read_o,
        input  write_o,
        input  burst_o
    );

endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cacheline read/writeback into a multi-beat memory burst and
// returns the assembled line or write completion to the cache as a single pulse.
module cacheline_burst_adaptor #(
    parameter int unsigned SLine  = 256,
    parameter int unsigned SBurst = 64
) (
    input logic                       clk,
    input logic                       rst,
    cacheline_burst_adaptor_if.slave  bus
);

    localparam int unsigned SBeats = SLine / SBurst;
    localparam int unsigned CntW   = (SBeats > 1) ? $clog2(SBeats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(SBeats - 1);
    // Byte offset bits within a line are cleared on the memory address.
    localparam logic [31:0] OffMask = 32'(SLine / 8 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdBurst,
        StRdDone,
        StWrBurst,
        StWrDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [SLine-1:0] wline_q, wline_d;
    logic [SLine-1:0] rline_q, rline_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;

        unique case (state_q)
            StIdle: begin
                // Writeback takes priority so dirty data is never lost behind a fill.
                if (bus.write_i) begin
                    addr_d  = bus.address_i;
                    wline_d = bus.line_i;
                    cnt_d   = '0;
                    state_d = StWrBurst;
                end else if (bus.read_i) begin
                    addr_d  = bus.address_i;
                    cnt_d   = '0;
                    state_d = StRdBurst;
                end
            end
            StRdBurst: begin
                if (bus.resp_i) begin
                    rline_d[SBurst*cnt_q +: SBurst] = bus.burst_i;
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        state_d = StRdDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRdDone: state_d = StIdle;
            StWrBurst: begin
                if (bus.resp_i) begin
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        state_d = StWrDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWrDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // All outputs decode from registered state only, so they cannot glitch.
    always_comb begin
        bus.read_o    = (state_q == StRdBurst);
        bus.write_o   = (state_q == StWrBurst);
        bus.resp_o    = (state_q == StRdDone) || (state_q == StWrDone);
        bus.address_o = addr_q & ~OffMask;
        bus.line_o    = rline_q;
        bus.burst_o   = '0;
        if (state_q == StWrBurst) begin
            bus.burst_o = wline_q[SBurst*cnt_q +: SBurst];
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench for cacheline_burst_adaptor: requests push expected
// completions and write beats; a negedge monitor pops and compares them.
module tb_cacheline_burst_adaptor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor_if #(.SLine(256), .SBurst(64)) bus ();

    cacheline_burst_adaptor #(
        .SLine  (256),
        .SBurst (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit           is_wr;
        logic [255:0] ln;
    } exp_t;

    exp_t         exp_q[$];
    logic [63:0]  beat_q[$];
    logic [255:0] last_rd = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rw_exclusive", 256'(bus.read_o & bus.write_o), '0);
            if (bus.write_o && bus.resp_i) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                else chk("burst_beat", bus.burst_o, beat_q.pop_front());
            end
            if (bus.resp_o) begin
                if (exp_q.size() == 0) begin
                    chk("resp_spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_wr) chk("wr_beats_left", 256'(beat_q.size()), '0);
                    else         chk("line_o", bus.line_o, e.ln);
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle. pat[i] is resp_i for burst cycle i
    // (1 beyond bit 31). abort_after>0 pulls reset after that many beats.
    // hold keeps the request up in the done cycle and drives a stray resp_i.
    task automatic run_burst(input bit is_wr, input bit both, input logic [31:0] addr,
                             input logic [255:0] ln, input logic [31:0] pat,
                             input int abort_after, input bit hold);
        int beat;
        int i;
        bus.write_i   = is_wr;
        bus.read_i    = !is_wr || both;
        bus.address_i = addr;
        bus.line_i    = is_wr ? ln : {4{64'hBAD0_BAD0_BAD0_BAD0}};
        if (abort_after <= 0) exp_q.push_back('{is_wr: is_wr, ln: ln});
        if (is_wr) for (int k = 0; k < 4; k++) beat_q.push_back(ln[64*k +: 64]);
        @(negedge clk);
        chk("idle_gap", 256'(bus.read_o | bus.write_o), '0);
        chk("line_o_retain", bus.line_o, last_rd);
        @(posedge clk); #1;
        bus.line_i = ~bus.line_i;
        beat = 0;
        i = 0;
        while (beat < 4 && i < 40) begin
            bus.resp_i  = (i < 32) ? pat[i] : 1'b1;
            bus.burst_i = bus.resp_i ? ln[64*beat +: 64] : 64'hDEAD_0000_0000_0000 + 64'(i);
            @(negedge clk);
            chk("address_o", bus.address_o, addr & 32'hFFFF_FFE0);
            if (is_wr) begin
                chk("write_o", bus.write_o, 1);
                chk("read_o_in_wr", bus.read_o, 0);
                chk("burst_o", bus.burst_o, ln[64*beat +: 64]);
            end else begin
                chk("read_o", bus.read_o, 1);
                chk("write_o_in_rd", bus.write_o, 0);
            end
            @(posedge clk); #1;
            if (bus.resp_i) beat++;
            i++;
            if (abort_after > 0 && beat == abort_after) begin
                rst = 1'b0;
                bus.read_i  = 1'b0;
                bus.write_i = 1'b0;
                bus.resp_i  = 1'b0;
                #1;
                chk("abort_read_o", bus.read_o, 0);
                chk("abort_resp_o", bus.resp_o, 0);
                chk("abort_line_o", bus.line_o, '0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                last_rd = '0;
                return;
            end
        end
        if (beat < 4) chk("burst_timeout", 256'(beat), 4);
        if (hold) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hFFFF_EEEE_DDDD_CCCC;
        end else begin
            bus.resp_i  = 1'b0;
            bus.read_i  = 1'b0;
            bus.write_i = 1'b0;
        end
        @(negedge clk);
        chk("resp_o", bus.resp_o, 1);
        chk("done_req_off", 256'(bus.read_o | bus.write_o), '0);
        if (!is_wr) last_rd = ln;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [255:0] ln_a;
        logic [255:0] ln_b;
        logic [255:0] ln_d;
        logic [255:0] ln_e;
        ln_a = {64'hA3A3_0003_A3A3_0003, 64'hA2A2_0002_A2A2_0002,
                64'hA1A1_0001_A1A1_0001, 64'hA0A0_0000_A0A0_0000};
        ln_b = {64'hB3B3_1111_2222_3333, 64'hB2B2_4444_5555_6666,
                64'hB1B1_7777_8888_9999, 64'hB0B0_AAAA_BBBB_CCCC};
        ln_d = {64'hD3D3_D3D3_0123_4567, 64'hD2D2_D2D2_89AB_CDEF,
                64'hD1D1_D1D1_FEDC_BA98, 64'hD0D0_D0D0_7654_3210};
        ln_e = {64'hE3E3_0000_1234_0003, 64'hE2E2_0000_1234_0002,
                64'hE1E1_0000_1234_0001, 64'hE0E0_0000_1234_0000};

        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.address_i = 32'hFFFF_FFFF;
        bus.line_i    = '1;
        bus.burst_i   = '1;
        bus.resp_i    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read_o", bus.read_o, 0);
        chk("rst_write_o", bus.write_o, 0);
        chk("rst_resp_o", bus.resp_o, 0);
        chk("rst_burst_o", bus.burst_o, 0);
        chk("rst_line_o", bus.line_o, 0);
        chk("rst_address_o", bus.address_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.resp_i = 1'b0;

        // Zero-gap read, unaligned address
        run_burst(1'b0, 1'b0, 32'h0000_00E7, ln_a, 32'hFFFF_FFFF, 0, 1'b0);
        // Gapped read: 1,0,0,1,1,0,1
        run_burst(1'b0, 1'b0, 32'h0000_4040, ln_b, 32'b1011001, 0, 1'b0);
        // Gapped write
        run_burst(1'b1, 1'b0, 32'h1234_5678, ln_d, 32'b1001011, 0, 1'b0);
        // Read and write together: write must win
        run_burst(1'b1, 1'b1, 32'h8000_001F, ln_e, 32'hFFFF_FFFF, 0, 1'b0);
        // Reset after two read beats, then a clean read
        run_burst(1'b0, 1'b0, 32'h0000_0100, ln_d, 32'hFFFF_FFFF, 2, 1'b0);
        run_burst(1'b0, 1'b0, 32'h0000_0200, ln_e, 32'b1101, 0, 1'b0);
        // Back-to-back read then write with held request and stray beats
        run_burst(1'b0, 1'b0, 32'h0000_0300, ln_b, 32'hFFFF_FFFF, 0, 1'b1);
        run_burst(1'b1, 1'b0, 32'h0000_0400, ln_a, 32'b110101, 0, 1'b0);
        run_burst(1'b0, 1'b0, 32'hFFFF_FFE1, ln_a, 32'b11, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("exp_q_drained", 256'(exp_q.size()), '0);
        chk("beat_q_drained", 256'(beat_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
